// File: rtl/pstep_counter.sv
// Valid/ready arithmetic stepper (ADD/SUB/ACC/SATADD) feeding a first-word-fall-through result FIFO.
// Define PSTEP_COUNTER_PARITY_EN to add the par_out port and per-entry parity storage.
module pstep_counter #(
    parameter int WIDTH  = 40,
    parameter int STEP_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             data_in,
    input  logic [1:0]                   mode,
    input  logic [STEP_W-1:0]            step,
    input  logic                         acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             data_out,
    output logic                         ovf_out,
`ifdef PSTEP_COUNTER_PARITY_EN
    output logic                         par_out,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_SAT = 2'b11;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] last_data_q, last_data_d;
    logic             last_ovf_q, last_ovf_d;
    logic [WIDTH-1:0] fifo_data_q [DEPTH];
    logic             fifo_ovf_q  [DEPTH];
`ifdef PSTEP_COUNTER_PARITY_EN
    logic             fifo_par_q  [DEPTH];
    logic             last_par_q, last_par_d;
`endif

    logic             full, empty, push, pop;
    logic [WIDTH-1:0] step_ext, acc_base, res;
    logic             res_ovf;
    logic [WIDTH:0]   sum_w, diff_w, accsum_w;

    // Result datapath: one extra MSB captures carry/borrow.
    always_comb begin
        step_ext = WIDTH'(step);
        acc_base = acc_clr ? '0 : acc_q;
        sum_w    = {1'b0, data_in} + {1'b0, step_ext};
        diff_w   = {1'b0, data_in} - {1'b0, step_ext};
        accsum_w = {1'b0, acc_base} + {1'b0, data_in};
        res      = sum_w[WIDTH-1:0];
        res_ovf  = sum_w[WIDTH];
        case (mode)
            MODE_SUB: begin
                res     = diff_w[WIDTH-1:0];
                res_ovf = diff_w[WIDTH];
            end
            MODE_ACC: begin
                res     = accsum_w[WIDTH-1:0];
                res_ovf = accsum_w[WIDTH];
            end
            MODE_SAT: begin
                if (sum_w[WIDTH]) begin
                    res     = '1;
                    res_ovf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        full        = (level_q == FULL_LVL);
        empty       = (level_q == '0);
        push        = in_valid & ~full;
        pop         = out_ready & ~empty;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d     = level_q;
        if (push && !pop) level_d = level_q + LVL_W'(1);
        if (pop && !push) level_d = level_q - LVL_W'(1);
        acc_d = acc_q;
        if (push && mode == MODE_ACC) acc_d = res;
        else if (acc_clr)             acc_d = '0;
        // Popped head is remembered so data_out holds it while the FIFO is empty.
        last_data_d = pop ? fifo_data_q[rd_ptr_q] : last_data_q;
        last_ovf_d  = pop ? fifo_ovf_q[rd_ptr_q]  : last_ovf_q;
`ifdef PSTEP_COUNTER_PARITY_EN
        last_par_d  = pop ? fifo_par_q[rd_ptr_q]  : last_par_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            acc_q       <= '0;
            last_data_q <= '0;
            last_ovf_q  <= 1'b0;
`ifdef PSTEP_COUNTER_PARITY_EN
            last_par_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            acc_q       <= acc_d;
            last_data_q <= last_data_d;
            last_ovf_q  <= last_ovf_d;
`ifdef PSTEP_COUNTER_PARITY_EN
            last_par_q  <= last_par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= res;
            fifo_ovf_q[wr_ptr_q]  <= res_ovf;
`ifdef PSTEP_COUNTER_PARITY_EN
            fifo_par_q[wr_ptr_q]  <= ^res;
`endif
        end
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign level     = level_q;
    assign data_out  = empty ? last_data_q : fifo_data_q[rd_ptr_q];
    assign ovf_out   = empty ? last_ovf_q  : fifo_ovf_q[rd_ptr_q];
`ifdef PSTEP_COUNTER_PARITY_EN
    assign par_out   = empty ? last_par_q  : fifo_par_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_pstep_counter.sv
// Randomized self-checking bench for pstep_counter against a queue-based arithmetic model.
module tb_pstep_counter;

    localparam int DEPTH = 4;
    localparam longint unsigned MOD = 64'd1 << 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, acc_clr;
    logic        in_ready, out_valid, ovf_out;
    logic [39:0] data_in, data_out;
    logic [1:0]  mode;
    logic [7:0]  step;
    logic [2:0]  level;
`ifdef PSTEP_COUNTER_PARITY_EN
    logic        par_out;
`endif

    pstep_counter #(.WIDTH(40), .STEP_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .mode(mode), .step(step), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .ovf_out(ovf_out),
`ifdef PSTEP_COUNTER_PARITY_EN
        .par_out(par_out),
`endif
        .level(level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [40:0]     q[$];
    longint unsigned acc_m = 0;

    // Values captured by tick() just before the active edge.
    logic        s_acc, s_pop, s_got_o, s_exp_o, s_rdy, s_exp_rdy, s_ov, s_exp_ov, s_got_p;
    logic [39:0] s_got_d, s_exp_d;
    logic [2:0]  s_level, s_exp_level;

    function automatic logic [40:0] model_op(input logic [1:0] m, input longint unsigned d,
                                             input longint unsigned st, input longint unsigned base);
        longint unsigned s;
        logic [39:0] r;
        logic o;
        case (m)
            2'd0: begin s = d + st; o = (s >= MOD); r = 40'(s % MOD); end
            2'd1: begin o = (st > d); r = 40'((d + MOD - st) % MOD); end
            2'd2: begin s = base + d; o = (s >= MOD); r = 40'(s % MOD); end
            default: begin
                s = d + st;
                if (s >= MOD) begin r = 40'(MOD - 1); o = 1'b1; end
                else begin r = 40'(s); o = 1'b0; end
            end
        endcase
        return {o, r};
    endfunction

    task automatic drive(input logic v, input logic [1:0] m, input logic [39:0] d,
                         input logic [7:0] st, input logic clr);
        in_valid = v; mode = m; data_in = d; step = st; acc_clr = clr;
    endtask

    task automatic tick();
        logic [40:0] e;
        longint unsigned base;
        #4;
        s_got_d = data_out; s_got_o = ovf_out; s_level = level; s_rdy = in_ready; s_ov = out_valid;
`ifdef PSTEP_COUNTER_PARITY_EN
        s_got_p = par_out;
`else
        s_got_p = ^data_out;
`endif
        s_exp_level = 3'(q.size());
        s_exp_rdy   = (q.size() < DEPTH);
        s_exp_ov    = (q.size() != 0);
        s_acc       = in_valid && (q.size() < DEPTH);
        s_pop       = out_ready && (q.size() != 0);
        if (s_pop) begin
            e = q.pop_front();
            s_exp_d = e[39:0];
            s_exp_o = e[40];
        end
        if (s_acc) begin
            base = acc_clr ? 0 : acc_m;
            e = model_op(mode, data_in, step, base);
            q.push_back(e);
            if (mode == 2'd2) acc_m = e[39:0];
            else if (acc_clr) acc_m = 0;
        end else if (acc_clr) begin
            acc_m = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 40'd0 || ovf_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values got level=%0d ov=%b rdy=%b d=%h o=%b want 0/0/1/0/0",
                     level, out_valid, in_ready, data_out, ovf_out);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 40'(100 + i), 8'd1, 1'b0);
            tick();
        end
        drive(1'b0, 2'd0, 40'd0, 8'd0, 1'b0);
        n_tests++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_prefill got level=%0d want 3", level);
        end
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 40'd0 || ovf_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midstream got level=%0d ov=%b rdy=%b d=%h o=%b want 0/0/1/0/0",
                     level, out_valid, in_ready, data_out, ovf_out);
        end
        q.delete();
        acc_m = 0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 2'd0, 40'd42, 8'd3, 1'b0);
        tick();
        drive(1'b0, 2'd0, 40'd0, 8'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (!s_pop || s_got_d !== 40'd45 || s_got_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_word got pop=%b d=%h o=%b want 1/2d/0", s_pop, s_got_d, s_got_o);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 40'h00_0000_0005, 8'd1, 1'b0);
        tick();
        drive(1'b1, 2'd0, 40'hFF_FFFF_FFFF, 8'd2, 1'b0);
        tick();
        n_tests++;
        if (s_ov !== 1'b1 || s_got_d !== 40'h6 || s_got_o !== 1'b0) begin
            n_fail++;
            $display("FAIL add_basic got ov=%b d=%h o=%b want 1/6/0", s_ov, s_got_d, s_got_o);
        end
        drive(1'b0, 2'd0, 40'd0, 8'd0, 1'b0);
        tick();
        n_tests++;
        if (s_got_d !== 40'h1 || s_got_o !== 1'b1) begin
            n_fail++;
            $display("FAIL add_carry got d=%h o=%b want 1/1", s_got_d, s_got_o);
        end
        tick();
        n_tests++;
        if (s_ov !== 1'b0 || s_got_d !== 40'h1 || s_level !== 3'd0) begin
            n_fail++;
            $display("FAIL add_empty_hold got ov=%b d=%h level=%0d want 0/1/0", s_ov, s_got_d, s_level);
        end
    endtask

    task automatic test_sub_sat();
        out_ready = 1'b1;
        drive(1'b1, 2'd1, 40'd0, 8'd1, 1'b0);
        tick();
        drive(1'b1, 2'd3, 40'hFF_FFFF_FFF0, 8'h20, 1'b0);
        tick();
        n_tests++;
        if (s_got_d !== 40'hFF_FFFF_FFFF || s_got_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_borrow got d=%h o=%b want ffffffffff/1", s_got_d, s_got_o);
        end
        drive(1'b1, 2'd3, 40'h00_0000_0010, 8'h20, 1'b0);
        tick();
        n_tests++;
        if (s_got_d !== 40'hFF_FFFF_FFFF || s_got_o !== 1'b1) begin
            n_fail++;
            $display("FAIL satadd_clip got d=%h o=%b want ffffffffff/1", s_got_d, s_got_o);
        end
        drive(1'b0, 2'd0, 40'd0, 8'd0, 1'b0);
        tick();
        n_tests++;
        if (s_got_d !== 40'h30 || s_got_o !== 1'b0) begin
            n_fail++;
            $display("FAIL satadd_noclip got d=%h o=%b want 30/0", s_got_d, s_got_o);
        end
    endtask

    task automatic test_acc();
        logic [39:0] want[5];
        int k;
        want = '{40'd10, 40'd30, 40'd60, 40'd7, 40'd4};
        k = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: drive(1'b1, 2'd2, 40'd10, 8'd99, 1'b0);
                1: drive(1'b1, 2'd2, 40'd20, 8'd99, 1'b0);
                2: drive(1'b1, 2'd2, 40'd30, 8'd99, 1'b0);
                3: drive(1'b1, 2'd2, 40'd7, 8'd0, 1'b1);
                4: drive(1'b0, 2'd2, 40'd0, 8'd0, 1'b1);
                5: drive(1'b1, 2'd2, 40'd4, 8'd0, 1'b0);
                default: drive(1'b0, 2'd0, 40'd0, 8'd0, 1'b0);
            endcase
            tick();
            if (s_pop) begin
                n_tests++;
                if (k > 4 || s_got_d !== want[k] || s_got_d !== s_exp_d || s_got_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL acc_seq[%0d] got d=%0d o=%b want %0d/0", k, s_got_d, s_got_o, s_exp_d);
                end
                k++;
            end
        end
        n_tests++;
        if (k !== 5) begin
            n_fail++;
            $display("FAIL acc_count got %0d results want 5", k);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd0, 40'(200 + 3 * i), 8'(i), 1'b0);
            tick();
            n_tests++;
            if (s_rdy !== s_exp_rdy || s_level !== s_exp_level) begin
                n_fail++;
                $display("FAIL bp_fill[%0d] got rdy=%b level=%0d want %b/%0d", i, s_rdy, s_level, s_exp_rdy, s_exp_level);
            end
        end
        n_tests++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full got level=%0d rdy=%b want 4/0", level, in_ready);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (s_rdy !== 1'b0 || !s_pop || s_got_d !== s_exp_d) begin
            n_fail++;
            $display("FAIL bp_pop_full got rdy=%b d=%h want 0/%h", s_rdy, s_got_d, s_exp_d);
        end
        tick();
        n_tests++;
        if (s_rdy !== 1'b1 || s_level !== 3'd3 || s_got_d !== s_exp_d) begin
            n_fail++;
            $display("FAIL bp_reopen got rdy=%b level=%0d d=%h want 1/3/%h", s_rdy, s_level, s_got_d, s_exp_d);
        end
        drive(1'b0, 2'd0, 40'd0, 8'd0, 1'b0);
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            tick();
            guard++;
            n_tests++;
            if (s_got_d !== s_exp_d || s_got_o !== s_exp_o || s_level !== s_exp_level) begin
                n_fail++;
                $display("FAIL bp_drain got d=%h o=%b level=%0d want %h/%b/%0d",
                         s_got_d, s_got_o, s_level, s_exp_d, s_exp_o, s_exp_level);
            end
        end
        n_tests++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain_timeout got ov=%b left=%0d want 0/0", out_valid, q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int guard;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r[39:8] = '1;
            drive(1'b1, 2'($urandom_range(0, 3)), r[39:0], 8'($urandom), ($urandom_range(0, 7) == 0));
            tick();
            if (i > 0) begin
                n_tests++;
                if (!s_pop || s_level !== 3'd1 || s_exp_level !== 3'd1 || s_got_d !== s_exp_d
                    || s_got_o !== s_exp_o || s_got_p !== ^s_exp_d) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] got pop=%b level=%0d d=%h o=%b p=%b want 1/1/%h/%b/%b",
                             i, s_pop, s_level, s_got_d, s_got_o, s_got_p, s_exp_d, s_exp_o, ^s_exp_d);
                end
            end
        end
        drive(1'b0, 2'd0, 40'd0, 8'd0, 1'b0);
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            tick();
            guard++;
            n_tests++;
            if (s_got_d !== s_exp_d || s_got_o !== s_exp_o) begin
                n_fail++;
                $display("FAIL b2b_tail got d=%h o=%b want %h/%b", s_got_d, s_got_o, s_exp_d, s_exp_o);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 2'd0, 40'd0, 8'd0, 1'b0);
        test_reset();
        test_add();
        test_sub_sat();
        test_acc();
        test_backpressure();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pstep_counter.md
Name: pstep_counter

Overview:
Parametrised successor to the 40-bit increment-by-one counter. Accepts words over a valid/ready handshake and applies a selectable arithmetic mode: add step, subtract step, saturating add, or running accumulate. Results are buffered in a first-word-fall-through output FIFO with per-word overflow flags. Sits between a stimulus/transactor interface and downstream consumers wherever the original incrementer was used.

Parameters:
WIDTH, 40, data path width in bits (>=2)
STEP_W, 8, width of step input (STEP_W <= WIDTH), zero-extended to WIDTH
DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept; equals !full
data_in  input  WIDTH  operand
mode  input  2  00 ADD, 01 SUB, 10 ACC, 11 SATADD; sampled with data_in on accept
step  input  STEP_W  step for ADD/SUB/SATADD; sampled on accept
acc_clr  input  1  clear accumulator (synchronous)
out_valid  output  1  FIFO head valid (!empty)
out_ready  input  1  consumer accepts head
data_out  output  WIDTH  FIFO head data
ovf_out  output  1  FIFO head overflow/underflow/saturation flag
level  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset is asynchronous and active-high: FIFO empty, level=0, out_valid=0, in_ready=1, data_out=0, ovf_out=0, accumulator=0.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Result is computed combinationally at accept and written into the FIFO tail on the same edge.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1 when the FIFO was empty.
- ADD: res = (data_in + step) mod 2^WIDTH; ovf = carry out.
- SUB: res = (data_in - step) mod 2^WIDTH; ovf = borrow.
- SATADD: if carry, res = all-ones and ovf=1; else res = sum and ovf=0.
- ACC: res = acc_next = (acc_base + data_in) mod 2^WIDTH; ovf = carry; accumulator <= acc_next.
  - acc_base is 0 if acc_clr=1 in the same cycle, else the current accumulator.
  - step is ignored in ACC.
- acc_clr without an ACC accept: accumulator <= 0 next edge. The accumulator is unaffected by other modes.
- Full (level==DEPTH): in_ready=0 and no accept. A pop in that cycle does not permit a same-cycle push; in_ready rises the following cycle.
- Empty: out_valid=0; data_out/ovf_out hold last popped values (don't care to consumer).
- Simultaneous push and pop (not full, not empty): level unchanged, ordering preserved.
- Pointers wrap modulo DEPTH. level is always the exact count.
- in_valid with in_ready=0: nothing sampled. The source must hold its data (standard valid/ready; valid must not drop before accept).
- Reset asserted mid-operation: all buffered words are discarded immediately, and outputs return to reset values asynchronously.

Optional Feature:
Macro PSTEP_COUNTER_PARITY_EN.
- Defined: extra output par_out (1 bit) = even parity (XOR reduce) of the stored WIDTH-bit result, computed at push and stored per FIFO entry. par_out is 0 after reset.
- Undefined: port and storage absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-stream with 3 words buffered -> level=0, out_valid=0, in_ready=1, data_out=0 immediately; next accepted word is the first one output.
- ADD: data_in=40'h00_0000_0005, step=1 -> data_out=40'h6, ovf_out=0, out_valid one cycle after accept. Then data_in=40'hFF_FFFF_FFFF, step=2 -> data_out=40'h1, ovf_out=1.
- SUB/SATADD: SUB data_in=0, step=1 -> 40'hFF_FFFF_FFFF with ovf=1. SATADD data_in=40'hFF_FFFF_FFF0, step=8'h20 -> 40'hFF_FFFF_FFFF with ovf=1.
- ACC: push 10, 20, 30 -> outputs 10, 30, 60. Then acc_clr with push 7 -> 7. acc_clr alone, then push 4 -> 4.
- Backpressure: out_ready=0, push 5 words (DEPTH=4) -> 4 accepted, in_ready=0, level=4. Pop one with push held -> in_ready returns the cycle after the pop, and all values come out in order.
- Concurrent: steady in_valid=1 and out_ready=1 for 100 random words/modes -> level stays at 1, one result per cycle, matching the scoreboard model.
